alarm_timekeeper: RTL and testbench

- Parametrised timekeeping and alarm core for the VGA clock.
- Generates the 1 Hz tick and keeps time in 12 h or 24 h mode. Applies debounced adjust pulses, runs the alarm state machine (with snooze and ring timeout) and produces the gated buzzer square wave.
- Sits between the button debouncers and the clock-face renderer.
- All outputs are registered.

---
 rtl/clock_pkg.sv | 18 +
 rtl/tick_divider.sv | 34 +++
 rtl/alarm_timekeeper.sv | 177 +++++++++++++++++
 tb/tb_alarm_timekeeper.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock core.
package clock_pkg;

  typedef enum logic [1:0] {
    Off     = 2'd0,
    Armed   = 2'd1,
    Ringing = 2'd2,
    Snoozed = 2'd3
  } alarm_state_e;

  localparam int unsigned SEC_PER_MIN = 60;
  localparam int unsigned MIN_PER_HR  = 60;

  function automatic int unsigned hmax(input int unsigned mode_24h);
    return (mode_24h != 0) ? 24 : 12;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Terminal-count prescaler: emits a registered one-cycle pulse every TC+1 cycles.
module tick_divider #(
  parameter int unsigned TC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic pulse
);

  localparam int unsigned W = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [W-1:0] cnt_q;
  logic         pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (clr) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (cnt_q == W'(TC)) begin
      cnt_q   <= '0;
      pulse_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      pulse_q <= 1'b0;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alarm_timekeeper.sv
// Timekeeping, adjust handling, alarm state machine and gated buzzer tone.
module alarm_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 31500000,
  parameter int unsigned BUZZ_HZ        = 3150,
  parameter bit          MODE_24H       = 1'b0,
  parameter int unsigned AL_MIN_STEP    = 10,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned RING_TIMEOUT_S = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  input  logic       snooze,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [5:0] al_minutes,
  output logic [4:0] al_hours,
  output logic       al_on,
  output logic       alarm,
  output logic       sec_tick,
  output logic       buzzer_out
);

  localparam int unsigned HMax    = hmax(int'(MODE_24H));
  localparam logic [4:0]  HLast   = 5'(HMax - 1);
  localparam logic [5:0]  SLast   = 6'(SEC_PER_MIN - 1);
  localparam logic [5:0]  MLast   = 6'(MIN_PER_HR - 1);
  localparam int unsigned HalfDiv = CLK_HZ / (2 * BUZZ_HZ);
  localparam int unsigned HalfPer = (HalfDiv < 1) ? 1 : HalfDiv;
  localparam int unsigned RingW   = $clog2(RING_TIMEOUT_S + 1);
  localparam int unsigned SnzW    = $clog2(SNOOZE_S + 1);

  logic [5:0] sec_q, sec_d, min_q, min_d, al_min_q, al_min_d;
  logic [4:0] hrs_q, hrs_d, al_hrs_q, al_hrs_d;
  logic [6:0] al_sum;
  logic       adj_any, carry_min, carry_hr;
  logic       match, match_q, trigger;
  logic       tone_pulse, tone_q;
  logic       al_on_q, alarm_q, buzz_q;
  logic [RingW-1:0] ring_q, ring_d;
  logic [SnzW-1:0]  snz_q, snz_d;
  alarm_state_e     state_q, state_d;

  tick_divider #(.TC(CLK_HZ - 1)) u_sec_div (
    .clk   (clk),
    .reset (reset),
    .clr   (sec_adj),
    .pulse (sec_tick)
  );

  tick_divider #(.TC(HalfPer - 1)) u_tone_div (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .pulse (tone_pulse)
  );

  // Any manual adjust suppresses the tick's carry for that cycle.
  always_comb begin
    adj_any   = sec_adj | min_adj | hrs_adj;
    carry_min = sec_tick && !adj_any && (sec_q == SLast);
    carry_hr  = carry_min && (min_q == MLast);

    sec_d = sec_q;
    if (sec_adj) sec_d = '0;
    else if (sec_tick) sec_d = (sec_q == SLast) ? '0 : sec_q + 6'd1;

    min_d = min_q;
    if (min_adj || carry_min) min_d = (min_q == MLast) ? '0 : min_q + 6'd1;

    hrs_d = hrs_q;
    if (hrs_adj || carry_hr) hrs_d = (hrs_q == HLast) ? '0 : hrs_q + 5'd1;

    al_sum   = {1'b0, al_min_q} + 7'(AL_MIN_STEP);
    al_min_d = al_min_q;
    al_hrs_d = al_hrs_q;
    if (al_adj) begin
      if (al_sum >= 7'(MIN_PER_HR)) begin
        al_min_d = 6'(al_sum - 7'(MIN_PER_HR));
        al_hrs_d = (al_hrs_q == HLast) ? '0 : al_hrs_q + 5'd1;
      end else begin
        al_min_d = al_sum[5:0];
      end
    end
  end

  assign match   = (hrs_q == al_hrs_q) && (min_q == al_min_q) && (sec_q == '0);
  assign trigger = match && !match_q;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    if (al_toggle) begin
      state_d = (state_q == Off) ? Armed : Off;
    end else begin
      unique case (state_q)
        Off: ;
        Armed: begin
          if (trigger) begin
            state_d = Ringing;
            ring_d  = '0;
          end
        end
        Ringing: begin
          if (snooze) begin
            state_d = Snoozed;
            snz_d   = SnzW'(SNOOZE_S - 1);
          end else if (sec_tick) begin
            if (ring_q == RingW'(RING_TIMEOUT_S - 1)) state_d = Armed;
            else ring_d = ring_q + 1'b1;
          end
        end
        Snoozed: begin
          if (sec_tick) begin
            if (snz_q == '0) begin
              state_d = Ringing;
              ring_d  = '0;
            end else begin
              snz_d = snz_q - 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_q    <= '0;
      min_q    <= '0;
      hrs_q    <= '0;
      al_min_q <= '0;
      al_hrs_q <= '0;
      match_q  <= 1'b0;
      state_q  <= Off;
      ring_q   <= '0;
      snz_q    <= '0;
      tone_q   <= 1'b0;
      al_on_q  <= 1'b0;
      alarm_q  <= 1'b0;
      buzz_q   <= 1'b0;
    end else begin
      sec_q    <= sec_d;
      min_q    <= min_d;
      hrs_q    <= hrs_d;
      al_min_q <= al_min_d;
      al_hrs_q <= al_hrs_d;
      match_q  <= match;
      state_q  <= state_d;
      ring_q   <= ring_d;
      snz_q    <= snz_d;
      tone_q   <= tone_q ^ tone_pulse;
      al_on_q  <= (state_d != Off);
      alarm_q  <= (state_d == Ringing);
      // Even seconds only: 1 s on, 1 s off cadence.
      buzz_q   <= alarm_q && !sec_q[0] && tone_q;
    end
  end

  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign hours      = hrs_q;
  assign al_minutes = al_min_q;
  assign al_hours   = al_hrs_q;
  assign al_on      = al_on_q;
  assign alarm      = alarm_q;
  assign buzzer_out = buzz_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Scoreboard bench: a 12 h and a 24 h instance share stimulus and are checked every cycle.
module tb_alarm_timekeeper;

  localparam int CLKHZ = 8;
  localparam int BUZZ  = 2;
  localparam int HALF  = CLKHZ / (2 * BUZZ);
  localparam int SNZ   = 3;
  localparam int RTO   = 4;
  localparam int STEP  = 10;

  localparam int S_OFF = 0, S_ARM = 1, S_RING = 2, S_SNZ = 3;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic [5:0] am;
    logic [4:0] ah;
    logic       tick;
    logic       al_on;
    logic       alarm;
    logic       buzz;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sec_adj = 0, min_adj = 0, hrs_adj = 0, al_adj = 0, al_toggle = 0, snooze = 0;

  logic [5:0] d_sec [2];
  logic [5:0] d_min [2];
  logic [4:0] d_hrs [2];
  logic [5:0] d_amin [2];
  logic [4:0] d_ahrs [2];
  logic       d_alon [2];
  logic       d_alarm [2];
  logic       d_tick [2];
  logic       d_buzz [2];

  int vectors = 0;
  int miscompares = 0;
  int ticks_seen = 0;
  bit count_ticks = 0;

  obs_t sb0[$];
  obs_t sb1[$];

  // Reference model state: time, alarm time, and the alarm mode per instance.
  int m_s[2], m_m[2], m_h[2], m_am[2], m_ah[2], m_st[2], m_ring[2], m_snz[2], m_phase[2];
  bit m_tick[2], m_mq[2], m_buzz[2];
  int m_ncyc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alarm_timekeeper #(
      .CLK_HZ(CLKHZ), .BUZZ_HZ(BUZZ), .MODE_24H(g == 1), .AL_MIN_STEP(STEP),
      .SNOOZE_S(SNZ), .RING_TIMEOUT_S(RTO)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .sec_adj    (sec_adj),
      .min_adj    (min_adj),
      .hrs_adj    (hrs_adj),
      .al_adj     (al_adj),
      .al_toggle  (al_toggle),
      .snooze     (snooze),
      .seconds    (d_sec[g]),
      .minutes    (d_min[g]),
      .hours      (d_hrs[g]),
      .al_minutes (d_amin[g]),
      .al_hours   (d_ahrs[g]),
      .al_on      (d_alon[g]),
      .alarm      (d_alarm[g]),
      .sec_tick   (d_tick[g]),
      .buzzer_out (d_buzz[g])
    );
  end

  function automatic obs_t got(input int k);
    obs_t o;
    o.s = d_sec[k]; o.m = d_min[k]; o.h = d_hrs[k]; o.am = d_amin[k]; o.ah = d_ahrs[k];
    o.tick = d_tick[k]; o.al_on = d_alon[k]; o.alarm = d_alarm[k]; o.buzz = d_buzz[k];
    return o;
  endfunction

  function automatic obs_t model_obs(input int k);
    obs_t o;
    o.s = 6'(m_s[k]); o.m = 6'(m_m[k]); o.h = 5'(m_h[k]);
    o.am = 6'(m_am[k]); o.ah = 5'(m_ah[k]);
    o.tick = m_tick[k]; o.al_on = (m_st[k] != S_OFF); o.alarm = (m_st[k] == S_RING);
    o.buzz = m_buzz[k];
    return o;
  endfunction

  // Tone is a square wave of period 2*HALF, first high HALF+1 cycles after reset.
  function automatic int tone_at(input int n);
    return (n == 0) ? 0 : ((n - 1) / HALF) % 2;
  endfunction

  task automatic compare(input string name, input obs_t g, input obs_t e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0d:%0d:%0d al=%0d:%0d tick=%0b on=%0b alarm=%0b buzz=%0b | want %0d:%0d:%0d al=%0d:%0d tick=%0b on=%0b alarm=%0b buzz=%0b",
               name, $time, g.h, g.m, g.s, g.ah, g.am, g.tick, g.al_on, g.alarm, g.buzz,
               e.h, e.m, e.s, e.ah, e.am, e.tick, e.al_on, e.alarm, e.buzz);
    end
  endtask

  task automatic check_int(input string name, input int g, input int e);
    vectors++;
    if (g != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, g, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s[k] = 0; m_m[k] = 0; m_h[k] = 0; m_am[k] = 0; m_ah[k] = 0; m_st[k] = S_OFF;
      m_ring[k] = 0; m_snz[k] = 0; m_phase[k] = 0; m_tick[k] = 0; m_mq[k] = 0; m_buzz[k] = 0;
    end
    m_ncyc = 0;
  endtask

  task automatic model_step(input bit sa, ma, ha, aa, at, sn);
    int tn;
    tn = tone_at(m_ncyc);
    for (int k = 0; k < 2; k++) begin
      int hm, ns, nm, nh, tot;
      bit tick, carry, carry_h, match, trig;
      hm = (k == 1) ? 24 : 12;
      tick = m_tick[k];
      match = (m_h[k] == m_ah[k]) && (m_m[k] == m_am[k]) && (m_s[k] == 0);
      trig = match && !m_mq[k];
      m_buzz[k] = (m_st[k] == S_RING) && (m_s[k] % 2 == 0) && (tn == 1);
      carry = tick && !(sa || ma || ha) && (m_s[k] == 59);
      carry_h = carry && (m_m[k] == 59);
      ns = sa ? 0 : (tick ? (m_s[k] + 1) % 60 : m_s[k]);
      nm = (m_m[k] + int'(ma) + int'(carry)) % 60;
      nh = (m_h[k] + int'(ha) + int'(carry_h)) % hm;
      if (aa) begin
        tot = m_am[k] + STEP;
        m_am[k] = tot % 60;
        m_ah[k] = (m_ah[k] + tot / 60) % hm;
      end
      m_tick[k] = !sa && (m_phase[k] == CLKHZ - 1);
      m_phase[k] = sa ? 0 : (m_phase[k] + 1) % CLKHZ;
      if (at) begin
        m_st[k] = (m_st[k] == S_OFF) ? S_ARM : S_OFF;
      end else if (m_st[k] == S_ARM && trig) begin
        m_st[k] = S_RING; m_ring[k] = 0;
      end else if (m_st[k] == S_RING) begin
        if (sn) begin
          m_st[k] = S_SNZ; m_snz[k] = 0;
        end else if (tick) begin
          m_ring[k]++;
          if (m_ring[k] == RTO) m_st[k] = S_ARM;
        end
      end else if (m_st[k] == S_SNZ && tick) begin
        m_snz[k]++;
        if (m_snz[k] == SNZ) begin
          m_st[k] = S_RING; m_ring[k] = 0;
        end
      end
      m_mq[k] = match;
      m_s[k] = ns; m_m[k] = nm; m_h[k] = nh;
    end
    m_ncyc++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit sa, ma, ha, aa, at, sn);
    sec_adj = sa; min_adj = ma; hrs_adj = ha; al_adj = aa; al_toggle = at; snooze = sn;
    model_step(sa, ma, ha, aa, at, sn);
    sb0.push_back(model_obs(0));
    sb1.push_back(model_obs(1));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit cond(input int what);
    case (what)
      0: return m_s[0] == 59;
      1: return m_s[0] == 0;
      2: return (m_s[0] == 59) && m_tick[0];
      3: return m_tick[0];
      4: return m_st[0] == S_RING;
      default: return m_st[0] == S_ARM;
    endcase
  endfunction

  task automatic wait_model(input int what, input int bound, input string name);
    int n;
    n = 0;
    while (!cond(what) && n < bound) begin
      idle(1);
      n++;
    end
    check_int(name, int'(cond(what)), 1);
  endtask

  task automatic check_zero(input string tag);
    compare({tag, "12"}, got(0), '0);
    compare({tag, "24"}, got(1), '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    sb0.delete();
    sb1.delete();
    sec_adj = 0; min_adj = 0; hrs_adj = 0; al_adj = 0; al_toggle = 0; snooze = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (count_ticks && d_tick[0]) ticks_seen++;
      if (sb0.size() > 0) compare("dut12", got(0), sb0.pop_front());
      if (sb1.size() > 0) compare("dut24", got(1), sb1.pop_front());
    end
  end

  initial begin : stimulus
    int n;
    #3;
    check_zero("por");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Free run: 10 tick pulses in the first 80 cycles, seconds lands on 10 next cycle.
    count_ticks = 1;
    idle(80);
    count_ticks = 0;
    check_int("tick_count", ticks_seen, 10);
    idle(1);
    check_int("sec_after_80", int'(d_sec[0]), 10);

    // 23 hour presses give 11 in 12 h mode and 23 in 24 h mode.
    for (int i = 0; i < 23; i++) step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0);
    wait_model(0, 600, "reach_59s");
    check_int("pre_roll_h12", int'(d_hrs[0]), 11);
    check_int("pre_roll_h24", int'(d_hrs[1]), 23);
    wait_model(1, 20, "rollover");
    check_int("roll_h12", int'(d_hrs[0]), 0);
    check_int("roll_h24", int'(d_hrs[1]), 0);
    check_int("roll_m12", int'(d_min[0]), 0);

    // min_adj on a carrying tick at 10:59:59: minutes wrap alone.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0);
    wait_model(2, 600, "reach_59s_tick");
    step(0, 1, 0, 0, 0, 0);
    check_int("coll_min", int'(d_min[0]), 0);
    check_int("coll_hrs", int'(d_hrs[0]), 10);
    check_int("coll_sec", int'(d_sec[0]), 0);

    // sec_adj on a tick restarts the second: next tick 8 cycles later.
    wait_model(3, 20, "reach_tick");
    step(1, 0, 0, 0, 0, 0);
    n = 0;
    while (!d_tick[0] && n < 20) begin
      idle(1);
      n++;
    end
    check_int("sec_adj_gap", n, 8);

    do_reset();
    for (int i = 0; i < 23; i++) step(0, 0, 0, 1, 0, 0);
    check_int("al_350_h", int'(d_ahrs[0]), 3);
    check_int("al_350_m", int'(d_amin[0]), 50);
    step(0, 0, 0, 1, 0, 0);
    check_int("al_400_h", int'(d_ahrs[0]), 4);
    check_int("al_400_m", int'(d_amin[0]), 0);
    for (int i = 0; i < 47; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check_int("al_wrap_h12", int'(d_ahrs[0]), 0);
    check_int("al_wrap_h24", int'(d_ahrs[1]), 12);

    // Ring at 0:10:00, snooze, re-ring, then time out back to armed.
    do_reset();
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    wait_model(4, 700, "ring_start");
    idle(16);
    check_int("ringing", int'(d_alarm[0]), 1);
    step(0, 0, 0, 0, 0, 1);
    check_int("snoozed_alarm", int'(d_alarm[0]), 0);
    check_int("snoozed_on", int'(d_alon[0]), 1);
    wait_model(4, 40, "re_ring");
    wait_model(5, 60, "timeout");
    idle(1);
    check_int("timeout_buzz", int'(d_buzz[0]), 0);
    check_int("timeout_on", int'(d_alon[0]), 1);

    // al_toggle beats snooze; re-arming inside the matching minute stays quiet.
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0);
    wait_model(4, 700, "ring_again");
    step(0, 0, 0, 0, 1, 1);
    check_int("prio_on", int'(d_alon[0]), 0);
    step(0, 0, 0, 0, 1, 0);
    idle(40);
    check_int("rearm_quiet", int'(d_alarm[0]), 0);
    check_int("rearm_on", int'(d_alon[0]), 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
           $urandom_range(15) == 0, $urandom_range(31) == 0, $urandom_range(15) == 0);
    end

    @(posedge clk);
    #2;
    check_int("sb_drain", sb0.size() + sb1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
